// File: rtl/rat_recovery_ctrl.sv
// Rename-state recovery sequencer.
// After a flush it copies the committed RAT snapshot into the front RAT one
// entry per cycle, then walks every physical tag and pushes the ones the
// snapshot does not reference into the free list. Rename stays stalled via
// o_recover_busy until the single-cycle o_recover_done pulse.
//
// state   | meaning
// IDLE    | waiting for a flush request
// RESTORE | writing snapshot entry r_idx into the front RAT, marking its tag
// FREE    | offering physical tag r_preg to the free list unless mapped
// DONE    | one-cycle completion pulse, then back to IDLE
module rat_recovery_ctrl #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_REGS  = 64,
  parameter int PHY_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_flush_req,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0] i_back_rat,
  output logic                           o_frat_we,
  output logic [4:0]                     o_frat_waddr,
  output logic [PHY_WIDTH-1:0]           o_frat_wdata,
  output logic                           o_fl_clear,
  output logic                           o_fl_push_valid,
  input  logic                           i_fl_push_ready,
  output logic [PHY_WIDTH-1:0]           o_fl_push_preg,
  output logic                           o_recover_busy,
  output logic                           o_recover_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    FREE    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [4:0]           LP_IDX_LAST  = 5'(ARCH_REGS - 1);
  localparam logic [PHY_WIDTH-1:0] LP_PREG_LAST = PHY_WIDTH'(PHY_REGS - 1);
  localparam logic [PHY_WIDTH-1:0] LP_PREG_ONE  = PHY_WIDTH'(1);

  state_t                         r_state;
  logic [4:0]                     r_idx;
  logic [PHY_WIDTH-1:0]           r_preg;
  logic [PHY_REGS-1:0]            r_mapped;
  logic [PHY_WIDTH*ARCH_REGS-1:0] r_snap;

  state_t                         w_state_nxt;
  logic [4:0]                     w_idx_nxt;
  logic [PHY_WIDTH-1:0]           w_preg_nxt;
  logic [PHY_REGS-1:0]            w_mapped_nxt;
  logic [PHY_WIDTH*ARCH_REGS-1:0] w_snap_nxt;
  logic                           w_start;
  logic [PHY_WIDTH-1:0]           w_tag;
  logic [PHY_WIDTH-1:0]           w_wdata_nxt;
  logic                           w_advance;

  assign w_start     = i_flush_req;
  assign w_tag       = r_snap[int'(r_idx)*PHY_WIDTH +: PHY_WIDTH];
  assign w_wdata_nxt = w_snap_nxt[int'(w_idx_nxt)*PHY_WIDTH +: PHY_WIDTH];
  // A free-list slot retires when it is either already mapped (skipped) or
  // accepted by the free list in this cycle.
  assign w_advance   = r_mapped[r_preg] || i_fl_push_ready;

  // Next-state, counter, snapshot and bitmap update; a flush wins from any state.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_preg_nxt   = r_preg;
    w_mapped_nxt = r_mapped;
    w_snap_nxt   = r_snap;
    if (w_start) begin
      w_state_nxt  = RESTORE;
      w_idx_nxt    = 5'd0;
      w_preg_nxt   = '0;
      w_mapped_nxt = '0;
      w_snap_nxt   = i_back_rat;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        RESTORE: begin
          // Out-of-range tags still reach the front RAT but own no bitmap slot.
          if (int'(w_tag) < PHY_REGS) begin
            w_mapped_nxt[w_tag] = 1'b1;
          end
          if (r_idx == LP_IDX_LAST) begin
            w_state_nxt = FREE;
            w_preg_nxt  = '0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
        FREE: begin
          if (w_advance) begin
            if (r_preg == LP_PREG_LAST) begin
              w_state_nxt = DONE;
            end else begin
              w_preg_nxt = r_preg + LP_PREG_ONE;
            end
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State registers plus outputs registered from the next-state values, so
  // every output reflects the state it belongs to without any input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_idx           <= 5'd0;
      r_preg          <= '0;
      r_mapped        <= '0;
      r_snap          <= '0;
      o_frat_we       <= 1'b0;
      o_frat_waddr    <= 5'd0;
      o_frat_wdata    <= '0;
      o_fl_clear      <= 1'b0;
      o_fl_push_valid <= 1'b0;
      o_fl_push_preg  <= '0;
      o_recover_busy  <= 1'b0;
      o_recover_done  <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_idx           <= w_idx_nxt;
      r_preg          <= w_preg_nxt;
      r_mapped        <= w_mapped_nxt;
      r_snap          <= w_snap_nxt;
      o_frat_we       <= (w_state_nxt == RESTORE);
      o_frat_waddr    <= (w_state_nxt == RESTORE) ? w_idx_nxt : 5'd0;
      o_frat_wdata    <= (w_state_nxt == RESTORE) ? w_wdata_nxt : '0;
      // Every entry into RESTORE (fresh start or restart) comes from a flush.
      o_fl_clear      <= w_start;
      o_fl_push_valid <= (w_state_nxt == FREE) && !w_mapped_nxt[w_preg_nxt];
      o_fl_push_preg  <= (w_state_nxt == FREE) ? w_preg_nxt : '0;
      o_recover_busy  <= (w_state_nxt != IDLE);
      o_recover_done  <= (w_state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Directed bench for rat_recovery_ctrl: flush/restore/free sequences with
// hand-derived cycle timelines relative to the flush cycle.
module tb_rat_recovery_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush_req;
  logic [191:0] back_rat;
  logic        frat_we;
  logic [4:0]  frat_waddr;
  logic [5:0]  frat_wdata;
  logic        fl_clear;
  logic        fl_push_valid;
  logic        fl_push_ready;
  logic [5:0]  fl_push_preg;
  logic        recover_busy;
  logic        recover_done;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] exp_snap [32];
  logic       exp_map  [64];
  int         pushes [$];

  rat_recovery_ctrl #(.ARCH_REGS(32), .PHY_REGS(64), .PHY_WIDTH(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush_req     (flush_req),
    .i_back_rat      (back_rat),
    .o_frat_we       (frat_we),
    .o_frat_waddr    (frat_waddr),
    .o_frat_wdata    (frat_wdata),
    .o_fl_clear      (fl_clear),
    .o_fl_push_valid (fl_push_valid),
    .i_fl_push_ready (fl_push_ready),
    .o_fl_push_preg  (fl_push_preg),
    .o_recover_busy  (recover_busy),
    .o_recover_done  (recover_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    0, 32'(frat_we), 0);
    chk({tag, "_waddr"}, 0, 32'(frat_waddr), 0);
    chk({tag, "_wdata"}, 0, 32'(frat_wdata), 0);
    chk({tag, "_clr"},   0, 32'(fl_clear), 0);
    chk({tag, "_pv"},    0, 32'(fl_push_valid), 0);
    chk({tag, "_pp"},    0, 32'(fl_push_preg), 0);
    chk({tag, "_busy"},  0, 32'(recover_busy), 0);
    chk({tag, "_done"},  0, 32'(recover_done), 0);
  endtask

  function automatic logic [191:0] pack_snap();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i*6 +: 6] = exp_snap[i];
    return v;
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 32; i++) exp_snap[i] = 6'(i);
  endtask

  // Called at a negedge: drives the flush pulse for the current cycle T.
  task automatic start_flush();
    flush_req     = 1'b1;
    back_rat      = pack_snap();
    fl_push_ready = 1'b1;
    for (int p = 0; p < 64; p++) exp_map[p] = 1'b0;
    for (int i = 0; i < 32; i++) exp_map[exp_snap[i]] = 1'b1;
    pushes.delete();
  endtask

  // Checks cycles T+1..T+kmax. A stall of stall_len ready-low cycles is
  // applied when preg 45 is first offered.
  task automatic run_pass(input string tag, input int stall_len, input int kmax);
    int j;
    int p;
    logic ev;
    logic rdy;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (k == 1) back_rat = ~back_rat;
      rdy = 1'b1;
      if (k <= 32) begin
        chk({tag, "_we"},    k, 32'(frat_we), 1);
        chk({tag, "_waddr"}, k, 32'(frat_waddr), k - 1);
        chk({tag, "_wdata"}, k, 32'(frat_wdata), 32'(exp_snap[k-1]));
        chk({tag, "_clr"},   k, 32'(fl_clear), (k == 1) ? 1 : 0);
        chk({tag, "_pv"},    k, 32'(fl_push_valid), 0);
        chk({tag, "_busy"},  k, 32'(recover_busy), 1);
        chk({tag, "_done"},  k, 32'(recover_done), 0);
      end else if (k <= 96 + stall_len) begin
        j = k - 33;
        if (j < 45) p = j;
        else if (j <= 45 + stall_len) p = 45;
        else p = j - stall_len;
        if (stall_len > 0 && j >= 45 && j < 45 + stall_len) rdy = 1'b0;
        ev = !exp_map[p];
        chk({tag, "_we"},   k, 32'(frat_we), 0);
        chk({tag, "_clr"},  k, 32'(fl_clear), 0);
        chk({tag, "_pv"},   k, 32'(fl_push_valid), 32'(ev));
        if (ev) chk({tag, "_pp"}, k, 32'(fl_push_preg), p);
        chk({tag, "_busy"}, k, 32'(recover_busy), 1);
        chk({tag, "_done"}, k, 32'(recover_done), 0);
      end else if (k == 97 + stall_len) begin
        chk({tag, "_we"},   k, 32'(frat_we), 0);
        chk({tag, "_pv"},   k, 32'(fl_push_valid), 0);
        chk({tag, "_busy"}, k, 32'(recover_busy), 1);
        chk({tag, "_done"}, k, 32'(recover_done), 1);
      end else begin
        chk({tag, "_busy"}, k, 32'(recover_busy), 0);
        chk({tag, "_done"}, k, 32'(recover_done), 0);
        chk({tag, "_pv"},   k, 32'(fl_push_valid), 0);
      end
      fl_push_ready = rdy;
      if (fl_push_valid && rdy) pushes.push_back(int'(fl_push_preg));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    flush_req     = 1'b0;
    back_rat      = '0;
    fl_push_ready = 1'b1;
    set_identity();

    // Reset state
    @(negedge clk);
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Case 1: identity map, ready always high
    start_flush();
    run_pass("c1", 0, 98);
    chk("c1_npush", 0, 32'(pushes.size()), 32);
    if (pushes.size() == 32) begin
      chk("c1_first", 0, 32'(pushes[0]), 32);
      chk("c1_last",  0, 32'(pushes[31]), 63);
    end

    // Case 2: arch5 -> preg 40
    exp_snap[5] = 6'd40;
    @(negedge clk);
    start_flush();
    run_pass("c2", 0, 98);
    chk("c2_npush", 0, 32'(pushes.size()), 32);
    if (pushes.size() == 32) begin
      chk("c2_p0", 0, 32'(pushes[0]), 5);
      chk("c2_p1", 0, 32'(pushes[1]), 32);
      chk("c2_p9", 0, 32'(pushes[9]), 41);
    end

    // Case 3: identity, three ready-low cycles on preg 45
    set_identity();
    @(negedge clk);
    start_flush();
    run_pass("c3", 3, 101);
    chk("c3_npush", 0, 32'(pushes.size()), 32);

    // Case 4: restart while preg 50 is offered, new map arch i -> 63-i
    @(negedge clk);
    start_flush();
    run_pass("c4a", 0, 83);
    chk("c4_pv50", 0, 32'(fl_push_valid), 1);
    chk("c4_pp50", 0, 32'(fl_push_preg), 50);
    for (int i = 0; i < 32; i++) exp_snap[i] = 6'(63 - i);
    start_flush();
    run_pass("c4b", 0, 98);
    chk("c4_npush", 0, 32'(pushes.size()), 32);
    if (pushes.size() == 32) chk("c4_p31", 0, 32'(pushes[31]), 31);

    // Case 5: asynchronous reset mid-RESTORE at idx 10
    set_identity();
    @(negedge clk);
    start_flush();
    run_pass("c5a", 0, 11);
    chk("c5_idx", 0, 32'(frat_waddr), 10);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("c5_rst");
    @(negedge clk);
    chk_all_zero("c5_hold");
    rst_n = 1'b1;
    @(negedge clk);
    start_flush();
    run_pass("c5b", 0, 98);
    chk("c5_npush", 0, 32'(pushes.size()), 32);

    // Case 6: arch1 and arch2 both -> preg 33
    set_identity();
    exp_snap[1] = 6'd33;
    exp_snap[2] = 6'd33;
    @(negedge clk);
    start_flush();
    run_pass("c6", 0, 98);
    chk("c6_npush", 0, 32'(pushes.size()), 33);
    if (pushes.size() == 33) begin
      chk("c6_p0", 0, 32'(pushes[0]), 1);
      chk("c6_p1", 0, 32'(pushes[1]), 2);
      chk("c6_p2", 0, 32'(pushes[2]), 32);
      chk("c6_p3", 0, 32'(pushes[3]), 34);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
